// File: rtl/apb_if.sv
// ---------------------------------------------------------------------------
// apb_if -- APB3-style slave front end for the GPIO core.
//
// Turns zero-wait-state APB transfers into a single-cycle register interface:
// one write strobe per transfer, combinational address/data passthrough, and
// zero-latency read data. It also forwards the core interrupt (registered) and
// supplies the core clock and its active-high reset.
//
// Ports
//   PCLK        in   system clock, all state on rising edge
//   PRESETn     in   synchronous active-low reset
//   PSEL        in   APB select
//   PENABLE     in   APB enable (access phase)
//   PWRITE      in   1 = write, 0 = read
//   PWDATA      in   APB write data
//   PADDR       in   APB address
//   gpio_dat_o  in   read data from GPIO core
//   gpio_int_o  in   level interrupt from GPIO core
//   PREADY      out  transfer complete (high throughout every access cycle)
//   PRDATA      out  APB read data (zero outside read access cycles)
//   IRQ         out  gpio_int_o delayed by one PCLK
//   sys_clk     out  GPIO core clock (= PCLK)
//   sys_rst     out  GPIO core reset, active high (= ~PRESETn)
//   gpio_we     out  one-cycle write strobe to the GPIO core
//   gpio_addr   out  GPIO core address (= PADDR)
//   gpio_dat_i  out  GPIO core write data (= PWDATA)
// ---------------------------------------------------------------------------
module apb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] gpio_dat_o,
  input  logic                  gpio_int_o,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  IRQ,
  output logic                  sys_clk,
  output logic                  sys_rst,
  output logic                  gpio_we,
  output logic [ADDR_WIDTH-1:0] gpio_addr,
  output logic [DATA_WIDTH-1:0] gpio_dat_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   irq_q;
  logic   access_phase;

  // State tracks the APB phase seen on the previous cycle; it is what lets the
  // write strobe fire only on the first access cycle that follows a SETUP.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= gpio_int_o;
    end
  end

  always_comb begin
    state_d      = IDLE;
    access_phase = PSEL & PENABLE & PRESETn;
    PREADY       = 1'b0;
    gpio_we      = 1'b0;
    PRDATA       = '0;

    // Next state is simply the phase decoded from the current bus inputs.
    if (PSEL) begin
      state_d = PENABLE ? ACCESS : SETUP;
    end

    if (access_phase) begin
      PREADY = 1'b1;
      // A held ACCESS (state ACCESS) or an ACCESS with no SETUP (state IDLE)
      // completes on the bus but must not re-trigger the core write.
      gpio_we = PWRITE & (state_q == SETUP);
      if (!PWRITE) begin
        PRDATA = gpio_dat_o;
      end
    end
  end

  assign IRQ        = irq_q;
  assign sys_clk    = PCLK;
  assign sys_rst    = ~PRESETn;
  assign gpio_addr  = PADDR;
  assign gpio_dat_i = PWDATA;

endmodule

// File: tb/tb_apb_if.sv
module tb_apb_if;

  logic        clk = 1'b0;
  logic        rstn, psel, pen, pwr, int_in;
  logic [31:0] paddr, pwdata, dat_o;
  logic        pready, irq, sys_clk, sys_rst, gpio_we;
  logic [31:0] prdata, gpio_addr, gpio_dat_i;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  apb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .PCLK       (clk),
    .PRESETn    (rstn),
    .PSEL       (psel),
    .PENABLE    (pen),
    .PWRITE     (pwr),
    .PWDATA     (pwdata),
    .PADDR      (paddr),
    .gpio_dat_o (dat_o),
    .gpio_int_o (int_in),
    .PREADY     (pready),
    .PRDATA     (prdata),
    .IRQ        (irq),
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .gpio_we    (gpio_we),
    .gpio_addr  (gpio_addr),
    .gpio_dat_i (gpio_dat_i)
  );

  typedef struct {
    logic        rstn, psel, pen, pwr, int_in;
    logic [31:0] addr, wdata, rdata;
    logic        e_rdy, e_we, e_irq;
    logic [31:0] e_prd;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(logic r, logic s, logic e, logic w, logic i,
                              logic [31:0] a, logic [31:0] wd, logic [31:0] rd,
                              logic erdy, logic ewe, logic eirq, logic [31:0] eprd);
    vec_t v;
    v.rstn = r; v.psel = s; v.pen = e; v.pwr = w; v.int_in = i;
    v.addr = a; v.wdata = wd; v.rdata = rd;
    v.e_rdy = erdy; v.e_we = ewe; v.e_irq = eirq; v.e_prd = eprd;
    return v;
  endfunction

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  // Drive one cycle's inputs just after the rising edge.
  task automatic drive(input logic r, input logic s, input logic e, input logic w,
                       input logic i, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd);
    @(posedge clk);
    #1;
    rstn = r; psel = s; pen = e; pwr = w; int_in = i;
    paddr = a; pwdata = wd; dat_o = rd;
    #4;
  endtask

  task automatic check_all(input int cyc, input logic e_rdy, input logic e_we,
                           input logic e_irq, input logic [31:0] e_prd);
    chk("PREADY", cyc, {31'd0, pready}, {31'd0, e_rdy});
    chk("gpio_we", cyc, {31'd0, gpio_we}, {31'd0, e_we});
    chk("IRQ", cyc, {31'd0, irq}, {31'd0, e_irq});
    chk("PRDATA", cyc, prdata, e_prd);
    chk("sys_rst", cyc, {31'd0, sys_rst}, {31'd0, ~rstn});
    chk("sys_clk", cyc, {31'd0, sys_clk}, {31'd0, clk});
    chk("gpio_addr", cyc, gpio_addr, paddr);
    chk("gpio_dat_i", cyc, gpio_dat_i, pwdata);
    $display("cyc %0d rstn=%b psel=%b pen=%b pwr=%b int=%b | rdy=%b we=%b irq=%b prdata=%h",
             cyc, rstn, psel, pen, pwr, int_in, pready, gpio_we, irq, prdata);
  endtask

  // Reference model: remembers only the previous cycle's bus inputs.
  // A write strobes when the previous cycle was a (non-reset) setup phase;
  // IRQ shows the interrupt level seen at the last edge, or 0 if that edge was in reset.
  logic prev_setup, prev_irq;

  task automatic model_advance();
    prev_setup = rstn & psel & ~pen;
    prev_irq   = rstn & int_in;
  endtask

  initial begin
    rstn = 1'b0; psel = 1'b0; pen = 1'b0; pwr = 1'b0; int_in = 1'b0;
    paddr = '0; pwdata = '0; dat_o = '0;

    //             rstn psel pen pwr int  addr          wdata   rdata    rdy we irq prdata
    tbl[0]  = mk(0, 1, 1, 1, 1, 32'h0000_1234, 32'd7,   32'd99,  0, 0, 0, 32'd0);
    tbl[1]  = mk(0, 1, 1, 1, 1, 32'h0000_1234, 32'd7,   32'd99,  0, 0, 0, 32'd0);
    tbl[2]  = mk(0, 1, 1, 1, 1, 32'h0000_1234, 32'd7,   32'd99,  0, 0, 0, 32'd0);
    tbl[3]  = mk(1, 0, 0, 0, 0, 32'h0,         32'd0,   32'd0,   0, 0, 0, 32'd0);
    tbl[4]  = mk(1, 1, 0, 0, 0, 32'hF0F0_FFFF, 32'd0,   32'd201, 0, 0, 0, 32'd0);
    tbl[5]  = mk(1, 1, 1, 0, 0, 32'hF0F0_FFFF, 32'd0,   32'd201, 1, 0, 0, 32'd201);
    tbl[6]  = mk(1, 1, 0, 1, 0, 32'hFFFF_0F0F, 32'd201, 32'd5,   0, 0, 0, 32'd0);
    tbl[7]  = mk(1, 1, 1, 1, 0, 32'hFFFF_0F0F, 32'd201, 32'd5,   1, 1, 0, 32'd0);
    tbl[8]  = mk(1, 1, 1, 1, 0, 32'hFFFF_0F0F, 32'd201, 32'd5,   1, 0, 0, 32'd0);
    tbl[9]  = mk(1, 1, 1, 1, 0, 32'hFFFF_0F0F, 32'd201, 32'd5,   1, 0, 0, 32'd0);
    tbl[10] = mk(1, 0, 1, 0, 1, 32'h0000_0040, 32'd3,   32'd77,  0, 0, 0, 32'd0);
    tbl[11] = mk(1, 0, 1, 1, 1, 32'h0000_0044, 32'd3,   32'd77,  0, 0, 1, 32'd0);
    tbl[12] = mk(1, 0, 0, 0, 0, 32'h0,         32'd0,   32'd0,   0, 0, 1, 32'd0);
    tbl[13] = mk(1, 0, 0, 0, 0, 32'h0,         32'd0,   32'd0,   0, 0, 0, 32'd0);
    tbl[14] = mk(1, 1, 1, 1, 0, 32'h0000_0010, 32'd9,   32'd0,   1, 0, 0, 32'd0);
    tbl[15] = mk(1, 1, 0, 1, 0, 32'h0000_0020, 32'd11,  32'd0,   0, 0, 0, 32'd0);
    tbl[16] = mk(0, 1, 1, 0, 0, 32'h0000_0020, 32'd11,  32'd55,  0, 0, 0, 32'd0);
    tbl[17] = mk(1, 1, 1, 1, 0, 32'h0000_0020, 32'd11,  32'd55,  1, 0, 0, 32'd0);

    // Let the first edge sample reset so IRQ and the phase history are defined.
    @(posedge clk);

    for (int k = 0; k < 18; k++) begin
      drive(tbl[k].rstn, tbl[k].psel, tbl[k].pen, tbl[k].pwr, tbl[k].int_in,
            tbl[k].addr, tbl[k].wdata, tbl[k].rdata);
      check_all(k, tbl[k].e_rdy, tbl[k].e_we, tbl[k].e_irq, tbl[k].e_prd);
      model_advance();
    end

    // Random traffic against the phase-history model.
    for (int k = 0; k < 1500; k++) begin
      logic        r, s, e, w, i;
      logic        e_acc;
      logic [31:0] rd;
      r  = ($urandom_range(0, 15) != 0);
      s  = ($urandom_range(0, 3) != 0);
      e  = $urandom_range(0, 1);
      w  = $urandom_range(0, 1);
      i  = $urandom_range(0, 1);
      rd = $urandom;
      drive(r, s, e, w, i, $urandom, $urandom, rd);
      e_acc = r & s & e;
      check_all(100 + k, e_acc, e_acc & w & prev_setup, prev_irq,
                (e_acc & ~w) ? rd : 32'd0);
      model_advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
